wb_commit: RTL and testbench

WB_COMMIT -- requirements
Module: wb_commit

---
 rtl/wb_commit.sv | 137 +++++++++++++
 tb/tb_wb_commit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_commit: dual-lane writeback merge into a single-port regfile    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_commit (
  input  logic        clk,
  input  logic        rst_s1,
  input  logic        a_we,
  input  logic        a_num,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_we,
  input  logic        b_num,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stop,
  input  logic [4:0]  fwd_raddr1,
  input  logic [4:0]  fwd_raddr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  localparam int DEPTH = 4;

  logic [1:0]  rptr_q, rptr_d;
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  wptr_p1;
  logic [2:0]  count_q, count_d;
  logic [3:0]  valid_q;
  logic [4:0]  addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];

  logic        a_ok, b_ok, pop;
  logic [1:0]  n_enq;
  logic [4:0]  first_addr, second_addr;
  logic [31:0] first_data, second_data;

  // Lane inputs are blocked while stalled; the upstream holds them for retry.
  assign a_ok    = a_we && (a_waddr != 5'd0) && !stop;
  assign b_ok    = b_we && (b_waddr != 5'd0) && !stop;
  assign pop     = (count_q != 3'd0);
  assign wptr_p1 = wptr_q + 2'd1;

  always_comb begin
    n_enq       = 2'd0;
    first_addr  = a_waddr;
    first_data  = a_wdata;
    second_addr = b_waddr;
    second_data = b_wdata;
    if (a_ok && b_ok) begin
      n_enq = 2'd2;
      if (a_num && !b_num) begin
        first_addr  = b_waddr;
        first_data  = b_wdata;
        second_addr = a_waddr;
        second_data = a_wdata;
      end
    end else if (a_ok) begin
      n_enq = 2'd1;
    end else if (b_ok) begin
      n_enq      = 2'd1;
      first_addr = b_waddr;
      first_data = b_wdata;
    end
  end

  assign count_d = count_q + {1'b0, n_enq} - {2'b00, pop};
  assign rptr_d  = rptr_q + {1'b0, pop};
  assign wptr_d  = wptr_q + n_enq;

  always_ff @(posedge clk) begin
    if (rst_s1) begin
      rptr_q  <= 2'd0;
      wptr_q  <= 2'd0;
      count_q <= 3'd0;
      valid_q <= 4'd0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      // Head and tail slots never coincide: occupancy peaks at 3 of 4.
      if (pop)
        valid_q[rptr_q] <= 1'b0;
      if (n_enq != 2'd0)
        valid_q[wptr_q] <= 1'b1;
      if (n_enq == 2'd2)
        valid_q[wptr_p1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s1 && n_enq != 2'd0) begin
      addr_q[wptr_q] <= first_addr;
      data_q[wptr_q] <= first_data;
    end
    if (!rst_s1 && n_enq == 2'd2) begin
      addr_q[wptr_p1] <= second_addr;
      data_q[wptr_p1] <= second_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s1)
      assert (count_d <= 3'd3) else $error("wb_commit: write into full FIFO");
  end

  assign stop     = (count_q >= 3'd3);
  assign rf_we    = (count_q != 3'd0);
  assign rf_waddr = rf_we ? addr_q[rptr_q] : 5'd0;
  assign rf_wdata = rf_we ? data_q[rptr_q] : 32'd0;

  // Scan oldest to youngest so the last match is the youngest pending write.
  function automatic logic [32:0] lookup(input logic [4:0] raddr);
    logic [32:0] res;
    logic [1:0]  idx;
    res = 33'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + 2'(k);
      if (raddr != 5'd0 && valid_q[idx] && addr_q[idx] == raddr)
        res = {1'b1, data_q[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_raddr1);
    {fwd_hit2, fwd_data2} = lookup(fwd_raddr2);
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// Directed scoreboard bench for wb_commit: expected regfile writes are
// queued at issue time and popped by an independent monitor.
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst_s1;
  logic        a_we, a_num, b_we, b_num;
  logic [4:0]  a_waddr, b_waddr;
  logic [31:0] a_wdata, b_wdata;
  logic        rf_we, stop;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  wb_commit dut (
    .clk(clk), .rst_s1(rst_s1),
    .a_we(a_we), .a_num(a_num), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_we(b_we), .b_num(b_num), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stop(stop),
    .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          mcnt    = 0;
  bit          started = 1'b0;
  logic [36:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (started) begin
      if (rf_we === 1'b1) begin
        if (expq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none", rf_waddr, rf_wdata);
        end else begin
          logic [36:0] e;
          e = expq.pop_front();
          chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
          chk("rf_wdata", rf_wdata, e[31:0]);
        end
      end else begin
        chk("idle_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("idle_wdata", rf_wdata, 32'd0);
      end
    end
  end

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input logic aw, input logic an, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bw, input logic bn, input logic [4:0] ba, input logic [31:0] bd,
                      output bit accepted);
    bit av, bv, stl;
    int n, p;
    a_we = aw; a_num = an; a_waddr = aa; a_wdata = ad;
    b_we = bw; b_num = bn; b_waddr = ba; b_wdata = bd;
    stl = (mcnt >= 3);
    chk("stop", {31'd0, stop}, {31'd0, stl});
    chk("rf_we", {31'd0, rf_we}, {31'd0, mcnt != 0});
    av = aw && aa != 5'd0 && !stl;
    bv = bw && ba != 5'd0 && !stl;
    n  = 0;
    if (av && bv) begin
      if (an && !bn) begin
        expq.push_back({ba, bd}); expq.push_back({aa, ad});
      end else begin
        expq.push_back({aa, ad}); expq.push_back({ba, bd});
      end
      n = 2;
    end else if (av) begin
      expq.push_back({aa, ad}); n = 1;
    end else if (bv) begin
      expq.push_back({ba, bd}); n = 1;
    end
    accepted = !stl;
    p = (mcnt != 0) ? 1 : 0;
    @(posedge clk);
    #1;
    if (rst_s1) begin
      expq.delete();
      mcnt = 0;
    end else begin
      mcnt = mcnt + n - p;
    end
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++)
      step(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, acc);
  endtask

  initial begin
    bit acc;
    int tries;
    logic [4:0]  ra [3];
    logic [31:0] rd [3];
    logic [1:0]  nums [3];

    rst_s1 = 1'b1;
    a_we = 0; a_num = 0; a_waddr = 0; a_wdata = 0;
    b_we = 0; b_num = 0; b_waddr = 0; b_wdata = 0;
    fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    rst_s1  = 1'b0;
    started = 1'b1;
    chk("rst_rf_we",  {31'd0, rf_we}, 32'd0);
    chk("rst_waddr",  {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata",  rf_wdata, 32'd0);
    chk("rst_stop",   {31'd0, stop}, 32'd0);
    chk("rst_hit1",   {31'd0, fwd_hit1}, 32'd0);
    chk("rst_hit2",   {31'd0, fwd_hit2}, 32'd0);
    chk("rst_fdata1", fwd_data1, 32'd0);
    chk("rst_fdata2", fwd_data2, 32'd0);

    // Single write, written exactly one cycle later.
    step(1, 0, 5'd5, 32'h11, 0, 0, 5'd0, 32'd0, acc);
    idle(2);

    // Dual lane, same address, lane B older; forward sees the younger A value.
    step(1, 1, 5'd3, 32'hA, 1, 0, 5'd3, 32'hB, acc);
    fwd_raddr1 = 5'd3; fwd_raddr2 = 5'd7;
    #1;
    chk("fwd_hit1_both",  {31'd0, fwd_hit1}, 32'd1);
    chk("fwd_data1_both", fwd_data1, 32'hA);
    chk("fwd_hit2_miss",  {31'd0, fwd_hit2}, 32'd0);
    chk("fwd_data2_miss", fwd_data2, 32'd0);
    idle(1);
    chk("fwd_data1_one", fwd_data1, 32'hA);
    idle(2);
    chk("fwd_hit1_empty", {31'd0, fwd_hit1}, 32'd0);

    // Write to r0 is discarded.
    step(1, 0, 5'd0, 32'h55, 0, 0, 5'd0, 32'd0, acc);
    fwd_raddr1 = 5'd0;
    #1;
    chk("r0_hit1", {31'd0, fwd_hit1}, 32'd0);
    chk("r0_data1", fwd_data1, 32'd0);
    idle(2);

    // Three back-to-back dual requests with stall-and-hold upstream.
    ra = '{5'd1, 5'd2, 5'd4}; rd = '{32'h100, 32'h200, 32'h400};
    nums = '{2'b01, 2'b10, 2'b00};
    for (int r = 0; r < 3; r++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 10) begin
        step(1, nums[r][1], ra[r], rd[r] + 32'h1,
             1, nums[r][0], ra[r] + 5'd8, rd[r] + 32'h2, acc);
        tries++;
      end
      if (!acc) begin
        vectors++; errors++;
        $display("FAIL stall_timeout: request %0d not accepted, got tries %0d expected <10", r, tries);
      end
    end
    idle(5);

    // Reset while full and lanes active drops everything.
    step(1, 0, 5'd6, 32'h61, 1, 1, 5'd7, 32'h71, acc);
    step(1, 0, 5'd6, 32'h62, 1, 1, 5'd7, 32'h72, acc);
    chk("pre_rst_stop", {31'd0, stop}, 32'd1);
    rst_s1 = 1'b1;
    step(1, 0, 5'd6, 32'h63, 1, 1, 5'd7, 32'h73, acc);
    rst_s1 = 1'b0;
    chk("post_rst_stop", {31'd0, stop}, 32'd0);
    chk("post_rst_we",   {31'd0, rf_we}, 32'd0);
    step(0, 0, 5'd0, 32'd0, 1, 1, 5'd9, 32'h99, acc);
    idle(2);

    // Ten single writes across both lanes wrap the pointers.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0)
        step(1, 1, 5'(10 + i), 32'hC000 + 32'(i), 0, 0, 5'd0, 32'd0, acc);
      else
        step(0, 0, 5'd0, 32'd0, 1, 0, 5'(10 + i), 32'hC000 + 32'(i), acc);
    end
    idle(3);

    chk("drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
